// File: rtl/io_ports_pkg.sv
// Shared constants for the memory-mapped I/O port block.
// Holds the default data/address widths and the two port addresses.
package io_ports_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_INPUT_PORT_ADDR  = 10'h3FE;
    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_OUTPUT_PORT_ADDR = 10'h3FF;

endpackage : io_ports_pkg

// File: rtl/io_ports.sv
// Memory-mapped I/O ports: one read-only input port and one write-only
// output port sitting on a simple strobe bus.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_write_en  bus write strobe
//   in_read_en   bus read strobe
//   in_data      bus write data
//   in_addr      bus address (fully decoded)
//   out_data     tri-state bus read data, driven only for input-port reads
//   in_port      external input pins, sampled every cycle
//   out_port     external output pins, driven straight from the output register
module io_ports
    import io_ports_pkg::*;
#(
    parameter int unsigned                DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned                ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]      INPUT_PORT_ADDR  = ADDR_WIDTH'(DEF_INPUT_PORT_ADDR),
    parameter logic [ADDR_WIDTH-1:0]      OUTPUT_PORT_ADDR = ADDR_WIDTH'(DEF_OUTPUT_PORT_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_write_en,
    input  logic                  in_read_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port
);

    // Power-up value of 0 so the pins read low before the first reset.
    logic [DATA_WIDTH-1:0] in_reg  = '0;
    logic [DATA_WIDTH-1:0] out_reg = '0;

    logic rd_sel;
    logic wr_sel;

    // Full-width compares: no address aliasing.
    assign rd_sel = in_read_en  && (in_addr == INPUT_PORT_ADDR);
    assign wr_sel = in_write_en && (in_addr == OUTPUT_PORT_ADDR);

    // Input sampler: free-running, one cycle of latency to the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_reg <= '0;
        end else begin
            in_reg <= in_port;
        end
    end

    // Output latch: reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
        end else if (wr_sel) begin
            out_reg <= in_data;
        end
    end

    // Read decode is purely combinational, so it ignores rst.
    assign out_data = rd_sel ? in_reg : {DATA_WIDTH{1'bz}};
    assign out_port = out_reg;

endmodule : io_ports

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports. The read bus carries a pullup so an
// undriven (high-impedance) bus is observed as all ones; every "Z" check
// is therefore made while the input register holds a value other than
// all ones, so a wrongly driven bus cannot masquerade as released.
module tb_io_ports;

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 10;
    localparam logic [AW-1:0] A_IN  = 10'h3FE;
    localparam logic [AW-1:0] A_OUT = 10'h3FF;
    localparam logic [DW-1:0] FLOAT = 4'b1111;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] pins_in = '0;
    wire  [DW-1:0] bus_rd;
    wire  [DW-1:0] pins_out;

    for (genvar g = 0; g < DW; g++) begin : g_pu
        pullup (bus_rd[g]);
    end

    io_ports dut (
        .clk         (clk),
        .rst         (rst),
        .in_write_en (write_en),
        .in_read_en  (read_en),
        .in_data     (wdata),
        .in_addr     (addr),
        .out_data    (bus_rd),
        .in_port     (pins_in),
        .out_port    (pins_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Behavioural model: what the pins and the bus must show.
    logic [DW-1:0] m_sampled = '0;
    logic [DW-1:0] m_latched = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_sampled = '0;
            m_latched = '0;
        end else begin
            m_sampled = pins_in;
            if (write_en && addr == A_OUT) m_latched = wdata;
        end
    end

    function automatic logic [DW-1:0] model_bus();
        if (read_en && addr == A_IN) return m_sampled;
        return FLOAT;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out_port", pins_out, m_latched);
            chk("cyc_out_data", bus_rd, model_bus());
        end
    end

    // Advance one rising edge, then settle outputs.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Power-up values before any edge or reset.
        read_en = 1'b1;
        addr    = A_IN;
        pins_in = 4'b1010;
        #1;
        chk("init_out_port", pins_out, 4'b0000);
        chk("init_in_reg", bus_rd, 4'b0000);
        cmp_en = 1'b1;

        tick();
        chk("first_sample", bus_rd, 4'b1010);

        // Reset clears the sampler; read decode still active during reset.
        rst = 1'b1;
        tick();
        chk("rst_read", bus_rd, 4'b0000);
        chk("rst_out_port", pins_out, 4'b0000);
        rst = 1'b0;

        // Read of a non-port address floats.
        pins_in = 4'b1100;
        addr    = 10'h055;
        tick();
        chk("rd_nonport", bus_rd, FLOAT);

        // Input port read, and mid-cycle pin change held off until the edge.
        addr = A_IN;
        tick();
        chk("rd_inport", bus_rd, 4'b1100);
        pins_in = 4'b0001;
        #1;
        chk("rd_hold", bus_rd, 4'b1100);
        tick();
        chk("rd_update", bus_rd, 4'b0001);

        // Writes: non-port address ignored, output port latches.
        read_en  = 1'b0;
        write_en = 1'b1;
        wdata    = 4'b1100;
        addr     = 10'h055;
        tick();
        chk("wr_nonport", pins_out, 4'b0000);
        addr = A_OUT;
        #1;
        chk("rd_disabled", bus_rd, FLOAT);
        tick();
        chk("wr_outport", pins_out, 4'b1100);

        // Output port is write-only.
        write_en = 1'b0;
        read_en  = 1'b1;
        addr     = A_OUT;
        #1;
        chk("rd_outaddr", bus_rd, FLOAT);

        // Simultaneous read and write of the input address: read works, write ignored.
        write_en = 1'b1;
        wdata    = 4'b1010;
        addr     = A_IN;
        tick();
        chk("wr_inaddr", pins_out, 4'b1100);
        chk("rd_during_wr", bus_rd, 4'b0001);

        // Full decode: addresses differing in one bit do not alias.
        addr = 10'h1FF;
        tick();
        chk("wr_alias", pins_out, 4'b1100);
        addr = 10'h3FC;
        #1;
        chk("rd_alias", bus_rd, FLOAT);

        // Read of input port and write of output port in the same cycle is
        // not possible (one address), but read_en + write_en to the output
        // port must still latch while the bus floats.
        pins_in = 4'b0110;
        wdata   = 4'b0011;
        addr    = A_OUT;
        tick();
        chk("wr_with_rd", pins_out, 4'b0011);
        chk("rd_float_wr", bus_rd, FLOAT);

        // Restore 1100, then reset dominates a coincident write.
        wdata = 4'b1100;
        tick();
        chk("wr_restore", pins_out, 4'b1100);
        read_en = 1'b0;
        rst     = 1'b1;
        wdata   = 4'b0111;
        tick();
        chk("rst_over_wr", pins_out, 4'b0000);
        rst = 1'b0;
        tick();
        chk("wr_after_rst", pins_out, 4'b0111);

        // A few extra cycles of mixed traffic for the per-cycle compare.
        write_en = 1'b0;
        read_en  = 1'b1;
        addr     = A_IN;
        for (int i = 0; i < 6; i++) begin
            pins_in  = 4'(i * 3 + 2);
            write_en = i[0];
            tick();
        end

        cmp_en = 1'b0;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_io_ports

// File: doc/io_ports.md
IO_PORTS -- requirements
Module: io_ports

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of bus data and both ports.
REQ-002 Parameter ADDR_WIDTH, default 10, width of bus address.
REQ-003 Parameter INPUT_PORT_ADDR, default 10'h3FE (10'b1111111110), bus address of the input port.
REQ-004 Parameter OUTPUT_PORT_ADDR, default 10'h3FF (10'b1111111111), bus address of the output port.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_write_en  input  1  bus write strobe.
REQ-008 in_read_en  input  1  bus read strobe.
REQ-009 in_data  input  DATA_WIDTH  bus write data.
REQ-010 in_addr  input  ADDR_WIDTH  bus address.
REQ-011 out_data  output  DATA_WIDTH  tri-state bus read data.
REQ-012 in_port  input  DATA_WIDTH  external input pins.
REQ-013 out_port  output  DATA_WIDTH  external output pins, registered.

Function
REQ-014 Input register in_reg SHALL capture in_port on every rising clk edge, independent of strobes; 1-cycle latency from in_port to bus.
REQ-015 out_data SHALL equal in_reg whenever in_read_en=1 and in_addr==INPUT_PORT_ADDR; decode is combinational on in_read_en/in_addr.
REQ-016 out_data SHALL be all-Z in every other case, including reads of OUTPUT_PORT_ADDR (output port is write-only) and any non-port address.
REQ-017 Change of in_port between clock edges SHALL NOT change out_data until the next rising edge.
REQ-018 Output register SHALL load in_data on a rising edge when in_write_en=1 and in_addr==OUTPUT_PORT_ADDR; otherwise hold.
REQ-019 out_port SHALL be driven directly from the output register.
REQ-020 Writes to INPUT_PORT_ADDR or any other address SHALL be ignored.
REQ-021 in_read_en and in_write_en asserted together SHALL each act independently per REQ-015/REQ-018.
REQ-022 Address comparison SHALL use all ADDR_WIDTH bits (full decode, no aliasing).

Reset
REQ-023 rst=1 at a rising edge SHALL clear output register and in_reg to 0; rst dominates a simultaneous write.
REQ-024 Output register and in_reg SHALL also have initial value 0, so out_port reads 0 before any reset or write.
REQ-025 out_data tri-state behaviour SHALL be unaffected by rst (combinational decode); during reset a valid read returns 0.

Structure
REQ-026 Port addresses and widths SHALL live in a shared package as constants used for parameter defaults.
REQ-027 Module SHALL be flat, no sub-modules; two registers plus combinational address decode.

Verification
REQ-028 read_en=1, in_port=4'b1100, addr=10'h055, clock -> out_data=4'bzzzz.
REQ-029 addr=10'h3FE, clock -> out_data=4'b1100; set in_port=4'b0001 without clock -> out_data stays 4'b1100; clock -> 4'b0001.
REQ-030 read_en=0, write_en=1, in_data=4'b1100, addr=10'h055, clock -> out_port=4'b0000; addr=10'h3FF, clock -> out_port=4'b1100.
REQ-031 read_en=1, addr=10'h3FF -> out_data=4'bzzzz; write_en=1 addr=10'h3FE data=4'b1010, clock -> out_port unchanged.
REQ-032 out_port=4'b1100, rst=1 with write_en=1 addr=10'h3FF data=4'b0111, clock -> out_port=4'b0000; release rst, clock -> out_port=4'b0111.
